// File: rtl/jtag_pkg.sv
// Shared TAP state encoding, opcode constants and the IEEE 1149.1 next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    ST_TLR,
    ST_RTI,
    ST_SEL_DR,
    ST_CAP_DR,
    ST_SHIFT_DR,
    ST_EXIT1_DR,
    ST_PAUSE_DR,
    ST_EXIT2_DR,
    ST_UPD_DR,
    ST_SEL_IR,
    ST_CAP_IR,
    ST_SHIFT_IR,
    ST_EXIT1_IR,
    ST_PAUSE_IR,
    ST_EXIT2_IR,
    ST_UPD_IR
  } tap_state_t;

  // BYPASS is all-ones at any IR width; callers cast to their IR width.
  localparam int BYPASS         = -1;
  localparam int IDCODE         = 1;
  localparam int SAMPLE_PRELOAD = 2;
  localparam int EXTEST         = 3;
  localparam int USER_BASE      = 4;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = ST_TLR;
    case (s)
      ST_TLR:      n = tms ? ST_TLR      : ST_RTI;
      ST_RTI:      n = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   n = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   n = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: n = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: n = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: n = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: n = tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   n = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   n = tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   n = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: n = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: n = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: n = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: n = tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   n = tms ? ST_SEL_DR   : ST_RTI;
      default:     n = ST_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state machine with registered state-level strobes.
//
// state       | meaning
// ST_TLR      | test-logic-reset, IDCODE forced active
// ST_RTI      | run-test/idle
// ST_SEL_*    | select DR / IR scan branch
// ST_CAP_*    | parallel load of the shift stage
// ST_SHIFT_*  | serial shift, tdo valid
// ST_EXIT1/2_*| shift exits around pause
// ST_PAUSE_*  | hold shift stage
// ST_UPD_*    | commit shift stage
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state,
  output logic       tap_reset,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr
);

  tap_state_t state_nxt;
  assign state_nxt = tap_next(state, tms);

  // Strobes are decoded from the next state so they line up exactly with state.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state      <= ST_TLR;
      tap_reset  <= 1'b1;
      capture_dr <= 1'b0;
      shift_dr   <= 1'b0;
      update_dr  <= 1'b0;
    end else begin
      state      <= state_nxt;
      tap_reset  <= (state_nxt == ST_TLR);
      capture_dr <= (state_nxt == ST_CAP_DR);
      shift_dr   <= (state_nxt == ST_SHIFT_DR);
      update_dr  <= (state_nxt == ST_UPD_DR);
    end
  end

endmodule

// File: rtl/jtag_tap_param.sv
// Parameterised JTAG TAP: IR, BYPASS and IDCODE registers, external channel select, tdo mux.
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
  parameter int          N_CHAN       = 2
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_en,
  output logic [N_CHAN-1:0] chan_sel,
  input  logic [N_CHAN-1:0] chan_tdo,
  output logic              capture_dr,
  output logic              shift_dr,
  output logic              update_dr,
  output logic              ext_mode,
  output logic              tap_reset
);

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_reg;
  logic [IR_WIDTH-1:0] ir_act;
  logic                bypass_reg;
  logic [31:0]         id_reg;
  logic                is_idcode;
  logic                chan_tdo_sel;

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .trst       (trst),
    .tms        (tms),
    .state      (state),
    .tap_reset  (tap_reset),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr)
  );

  // Data shift stages carry no reset; an aborted scan leaves them undefined.
  always_ff @(posedge tck) begin
    if (state == ST_CAP_IR)
      ir_shift <= IR_WIDTH'(1);
    else if (state == ST_SHIFT_IR)
      ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
    if (capture_dr) begin
      bypass_reg <= 1'b0;
      id_reg     <= IDCODE_VALUE;
    end else if (shift_dr) begin
      bypass_reg <= tdi;
      id_reg     <= {tdi, id_reg[31:1]};
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst)
      ir_reg <= IR_WIDTH'(IDCODE);
    else if (tap_reset)
      ir_reg <= IR_WIDTH'(IDCODE);
    else if (state == ST_UPD_IR)
      ir_reg <= ir_shift;
  end

  // TLR overrides immediately so IDCODE is active on the same edge that enters it.
  assign ir_act = tap_reset ? IR_WIDTH'(IDCODE) : ir_reg;

  always_comb begin
    chan_sel  = '0;
    ext_mode  = 1'b0;
    is_idcode = 1'b0;
    if (ir_act == IR_WIDTH'(BYPASS)) begin
      chan_sel = '0;
    end else if (ir_act == IR_WIDTH'(IDCODE)) begin
      is_idcode = 1'b1;
    end else if (ir_act == IR_WIDTH'(SAMPLE_PRELOAD)) begin
      chan_sel[0] = 1'b1;
    end else if (ir_act == IR_WIDTH'(EXTEST)) begin
      chan_sel[0] = 1'b1;
      ext_mode    = 1'b1;
    end else begin
      // USER codes that would alias the all-ones BYPASS code are excluded.
      for (int k = 0; k < N_CHAN - 1; k++) begin
        if ((USER_BASE + k) < ((1 << IR_WIDTH) - 1) && ir_act == IR_WIDTH'(USER_BASE + k))
          chan_sel[k+1] = 1'b1;
      end
    end
  end

  assign chan_tdo_sel = |(chan_sel & chan_tdo);

  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= (state == ST_SHIFT_IR) || (state == ST_SHIFT_DR);
      if (state == ST_SHIFT_IR)
        tdo <= ir_shift[0];
      else if (state == ST_SHIFT_DR)
        tdo <= (|chan_sel) ? chan_tdo_sel : (is_idcode ? id_reg[0] : bypass_reg);
      else
        tdo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap_param.sv
// Scoreboard bench for jtag_tap_param: expected tdo bits queued with stimulus, popped as shifted out.
module tb_jtag_tap_param;

  localparam int IR_WIDTH = 4;
  localparam int N_CHAN   = 2;

  logic              tck = 1'b0;
  logic              trst = 1'b1;
  logic              tms = 1'b1;
  logic              tdi = 1'b0;
  logic              tdo;
  logic              tdo_en;
  logic [N_CHAN-1:0] chan_sel;
  logic [N_CHAN-1:0] chan_tdo = '0;
  logic              capture_dr;
  logic              shift_dr;
  logic              update_dr;
  logic              ext_mode;
  logic              tap_reset;

  logic [31:0] idv = 32'h1000_0001;
  logic        exp_q[$];
  int          checks = 0;
  int          failures = 0;

  jtag_tap_param #(
    .IR_WIDTH     (IR_WIDTH),
    .IDCODE_VALUE (32'h1000_0001),
    .N_CHAN       (N_CHAN)
  ) dut (
    .tck        (tck),
    .trst       (trst),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .chan_sel   (chan_sel),
    .chan_tdo   (chan_tdo),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .ext_mode   (ext_mode),
    .tap_reset  (tap_reset)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full tck cycle; returns just after the falling edge so tdo is settled.
  task automatic step(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
    @(negedge tck);
    #1;
  endtask

  task automatic shift_bits(input string tag, input int n, input logic [31:0] din,
                            input logic exit_last);
    logic e;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_en"}, 32'(tdo_en), 32'd1);
      e = exp_q.pop_front();
      chk(tag, 32'(tdo), 32'(e));
      step(exit_last && (i == n - 1), din[i]);
    end
  endtask

  task automatic load_ir(input logic [IR_WIDTH-1:0] op);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    exp_q.push_back(1'b1);
    for (int i = 1; i < IR_WIDTH; i++) exp_q.push_back(1'b0);
    shift_bits("ir_capture", IR_WIDTH, 32'(op), 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic goto_shift_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("capture_dr", 32'(capture_dr), 32'd1);
    step(1'b0, 1'b0);
    chk("shift_dr", 32'(shift_dr), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge tck);
    #1;
    chk("rst_tdo", 32'(tdo), 32'd0);
    chk("rst_tdo_en", 32'(tdo_en), 32'd0);
    chk("rst_chan_sel", 32'(chan_sel), 32'd0);
    chk("rst_strobes", {29'd0, capture_dr, shift_dr, update_dr}, 32'd0);
    chk("rst_ext_mode", 32'(ext_mode), 32'd0);
    chk("rst_tap_reset", 32'(tap_reset), 32'd1);

    // IDCODE straight after reset, 32 bits LSB first
    trst = 1'b0;
    step(1'b0, 1'b0);
    chk("rti_tap_reset", 32'(tap_reset), 32'd0);
    goto_shift_dr();
    for (int i = 0; i < 32; i++) exp_q.push_back(idv[i]);
    shift_bits("idcode", 32, 32'h0, 1'b1);
    chk("exit1_tdo_en", 32'(tdo_en), 32'd0);
    step(1'b1, 1'b0);
    chk("update_dr", 32'(update_dr), 32'd1);
    step(1'b0, 1'b0);
    chk("rti_update_dr", 32'(update_dr), 32'd0);

    // IDCODE split by Pause-DR: the register must hold
    goto_shift_dr();
    for (int i = 0; i < 32; i++) exp_q.push_back(idv[i]);
    shift_bits("idcode_pre", 16, 32'h0, 1'b1);
    step(1'b0, 1'b1);
    chk("pause_tdo_en", 32'(tdo_en), 32'd0);
    chk("pause_tdo", 32'(tdo), 32'd0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    shift_bits("idcode_post", 16, 32'h0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // BYPASS: one-bit delay, captured 0 first
    load_ir(4'hF);
    chk("byp_chan_sel", 32'(chan_sel), 32'd0);
    chk("byp_ext_mode", 32'(ext_mode), 32'd0);
    goto_shift_dr();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    shift_bits("bypass", 3, 32'b101, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // USER 0 -> channel 1, strobe sequence through a DR pass
    load_ir(4'h4);
    chk("user_chan_sel", 32'(chan_sel), 32'b10);
    chk("user_ext_mode", 32'(ext_mode), 32'd0);
    step(1'b1, 1'b0);
    chk("seldr_strobes", {29'd0, capture_dr, shift_dr, update_dr}, 32'b000);
    step(1'b0, 1'b0);
    chk("cap_strobes", {29'd0, capture_dr, shift_dr, update_dr}, 32'b100);
    chan_tdo = 2'b10;
    step(1'b0, 1'b0);
    chk("shift_strobes", {29'd0, capture_dr, shift_dr, update_dr}, 32'b010);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    chk("user_tdo0", 32'(tdo), 32'(exp_q.pop_front()));
    chan_tdo = 2'b01;
    step(1'b0, 1'b0);
    chk("user_tdo1", 32'(tdo), 32'(exp_q.pop_front()));
    step(1'b1, 1'b0);
    chk("exit1_strobes", {29'd0, capture_dr, shift_dr, update_dr}, 32'b000);
    step(1'b1, 1'b0);
    chk("upd_strobes", {29'd0, capture_dr, shift_dr, update_dr}, 32'b001);
    step(1'b0, 1'b0);
    chk("rti_strobes", {29'd0, capture_dr, shift_dr, update_dr}, 32'b000);

    // EXTEST, then trst mid-shift
    load_ir(4'h3);
    chk("ext_ext_mode", 32'(ext_mode), 32'd1);
    chk("ext_chan_sel", 32'(chan_sel), 32'b01);
    chan_tdo = 2'b01;
    goto_shift_dr();
    exp_q.push_back(1'b1);
    chk("ext_tdo", 32'(tdo), 32'(exp_q.pop_front()));
    trst = 1'b1;
    #1;
    chk("abort_ext_mode", 32'(ext_mode), 32'd0);
    chk("abort_chan_sel", 32'(chan_sel), 32'd0);
    chk("abort_tdo_en", 32'(tdo_en), 32'd0);
    chk("abort_tap_reset", 32'(tap_reset), 32'd1);
    chk("abort_shift_dr", 32'(shift_dr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("abort_update_dr", 32'(update_dr), 32'd0);
    end
    trst = 1'b0;

    // Five tms=1 edges from Shift-IR reach TLR with IDCODE active
    step(1'b0, 1'b0);
    load_ir(4'h3);
    chk("ext2_ext_mode", 32'(ext_mode), 32'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("shift_ir_tdo_en", 32'(tdo_en), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      chk("tms_walk_tap_reset", 32'(tap_reset), 32'd0);
    end
    step(1'b1, 1'b0);
    chk("tms5_tap_reset", 32'(tap_reset), 32'd1);
    chk("tms5_ext_mode", 32'(ext_mode), 32'd0);
    chk("tms5_chan_sel", 32'(chan_sel), 32'd0);
    step(1'b0, 1'b0);
    goto_shift_dr();
    for (int i = 0; i < 8; i++) exp_q.push_back(idv[i]);
    shift_bits("tlr_idcode", 8, 32'h0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_tap_param.md
JTAG_TAP_PARAM -- requirements
Module: jtag_tap_param

Interface
REQ-001 Parameter IR_WIDTH, default 4: instruction register width, minimum 2.
REQ-002 Parameter IDCODE_VALUE, default 32'h1000_0001: device ID word; bit 0 SHALL be 1.
REQ-003 Parameter N_CHAN, default 2: external data-register channels, minimum 1.
REQ-004 tck  in  1  sole clock; all state uses rising edge except tdo/tdo_en, which use falling edge.
REQ-005 trst  in  1  asynchronous, active-high reset.
REQ-006 tms  in  1  TAP mode select, sampled on rising tck.
REQ-007 tdi  in  1  serial data in, sampled on rising tck.
REQ-008 tdo  out  1  serial data out.
REQ-009 tdo_en  out  1  high while tdo is valid.
REQ-010 chan_sel  out  N_CHAN  one-hot external channel select, all zero when no channel is selected.
REQ-011 chan_tdo  in  N_CHAN  serial outputs of the external channels.
REQ-012 capture_dr / shift_dr / update_dr  out  1 each  level high while the FSM is in Capture-DR / Shift-DR / Update-DR.
REQ-013 ext_mode  out  1  high while the active instruction is EXTEST.
REQ-014 tap_reset  out  1  high while the FSM is in Test-Logic-Reset.

Function
REQ-015 FSM SHALL implement the 16 IEEE 1149.1 states with standard TMS transitions (TLR, RTI, Select-DR/IR, Capture, Shift, Exit1, Pause, Exit2, Update for both DR and IR).
REQ-016 Five consecutive tms=1 rising edges SHALL reach TLR from any state.
REQ-017 Capture-IR SHALL load the IR shift stage with IR_WIDTH'b...01: bit0=1, bit1=0, upper bits 0.
REQ-018 Shift-IR SHALL shift right one bit per tck, taking tdi into the MSB; tdo SHALL present the LSB.
REQ-019 Update-IR SHALL copy the shift stage to the active instruction; the active instruction SHALL NOT change in any other state.
REQ-020 In TLR the active instruction SHALL be IDCODE.
REQ-021 Decode: all-ones=BYPASS; 1=IDCODE; 2=SAMPLE_PRELOAD; 3=EXTEST; 4+k=USER k for k=0..N_CHAN-2; all other codes=BYPASS.
REQ-022 SAMPLE_PRELOAD and EXTEST SHALL set chan_sel[0]; USER k SHALL set chan_sel[k+1]; chan_sel SHALL update only when the active instruction changes.
REQ-023 BYPASS: a 1-bit register SHALL load 0 in Capture-DR and take tdi in Shift-DR, giving a one-bit tdi-to-tdo delay.
REQ-024 IDCODE: a 32-bit register SHALL load IDCODE_VALUE in Capture-DR and shift right, LSB first.
REQ-025 External channels SHALL be driven only by capture_dr, shift_dr and update_dr; tdo in Shift-DR SHALL be chan_tdo[selected].
REQ-026 tdo and tdo_en SHALL be registered on falling tck. tdo_en SHALL be 1 only when the FSM is in Shift-IR or Shift-DR; otherwise tdo SHALL be 0.
REQ-027 Pause-IR and Pause-DR SHALL hold every shift register unchanged.

Reset
REQ-028 On trst=1 the FSM SHALL enter TLR and the active instruction SHALL be IDCODE.
REQ-029 On trst=1 the outputs SHALL be: tdo=0, tdo_en=0, chan_sel=0, capture_dr=0, shift_dr=0, update_dr=0, ext_mode=0, tap_reset=1.
REQ-030 trst mid-shift SHALL abort the shift with no Update strobe and leave the shift registers undefined.

Structure
REQ-031 Package jtag_pkg SHALL hold the tap_state_t enum and the opcode constants BYPASS, IDCODE, SAMPLE_PRELOAD, EXTEST and USER_BASE=4.
REQ-032 The FSM SHALL be the sub-module jtag_tap_fsm, which outputs the state and the decoded strobes.

Verification
REQ-033 Release trst, go TLR->RTI->Shift-DR, shift 32 bits -> tdo sequence equals 32'h1000_0001, LSB first.
REQ-034 From Shift-IR, clock tms=1 five times -> tap_reset=1 after the fifth edge and the active instruction is IDCODE.
REQ-035 Capture-IR then shift 4 bits with IR_WIDTH=4 -> tdo reads 1,0,0,0.
REQ-036 Load BYPASS (4'hF) and shift tdi=1,0,1 in Shift-DR -> tdo=0,1,0 (first bit is the captured 0).
REQ-037 Load 4'h4 with N_CHAN=2 -> chan_sel=2'b10 after Update-IR; the DR pass shows capture_dr, then shift_dr, then update_dr, each for exactly its state.
REQ-038 Assert trst during Shift-DR under EXTEST -> same cycle: ext_mode=0, chan_sel=0, tdo_en=0, no update_dr pulse.
